// File: rtl/zap_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zap_arb_pkg
//  Description : Shared types and constants for the ZAP memory arbiter:
//                FSM state encoding, served-port encoding and the default
//                transaction timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package zap_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Port that owns the current transaction
  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } arb_port_t;

  // Cycles o_m_req may stay high without an acknowledge
  localparam int DEFAULT_TIMEOUT = 16;

endpackage
`default_nettype wire

// File: rtl/zap_arb_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : zap_arb_timeout
//  Description : Loadable down-counter used as the per-transaction watchdog.
//                Loaded once per grant, decrements while enabled, and flags
//                expiry while enabled with a count of zero.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                clear            - force count to zero (highest priority)
//                load, load_value - reload the counter
//                en               - count this cycle
//                expire           - en while count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module zap_arb_timeout
  import zap_arb_pkg::*;
#(
  parameter int WIDTH = $clog2(DEFAULT_TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Gated by en so a cleared, idle counter never reports expiry
  assign expire = en && (count == '0);

endmodule
`default_nettype wire

// File: rtl/zap_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : zap_mem_arbiter
//  Description : Shares one single-ported, variable-latency memory between
//                the ZAP instruction-fetch port and data port. Data has
//                fixed priority over fetch; every transaction is bounded by
//                a watchdog that converts a missing acknowledge into an abort.
//  Ports       : i_clk, i_reset_n  - clock, async active-low reset
//                i_d_* / o_d_*     - core data port (stall/abort handshake)
//                i_i_* / o_i_*     - core fetch port (valid/abort pulses)
//                o_m_* / i_m_*     - backing memory request/ack interface
//  Options     : ZAP_ARB_FAIRNESS_EN - after MAX_DATA_BURST consecutive data
//                grants with a fetch pending, the fetch is granted next.
//  Revision    : 1.0 - initial release
// ============================================================================
module zap_mem_arbiter
  import zap_arb_pkg::*;
#(
  parameter int TIMEOUT        = DEFAULT_TIMEOUT,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_d_rd_en,
  input  logic        i_d_wr_en,
  input  logic [31:0] i_d_address,
  input  logic [31:0] i_d_wr_data,
  input  logic [3:0]  i_d_be,
  output logic [31:0] o_d_rd_data,
  output logic        o_d_stall,
  output logic        o_d_abort,
  input  logic        i_i_rd_en,
  input  logic [31:0] i_i_address,
  output logic [31:0] o_i_data,
  output logic        o_i_valid,
  output logic        o_i_abort,
  output logic        o_m_req,
  output logic        o_m_we,
  output logic [31:0] o_m_address,
  output logic [31:0] o_m_wr_data,
  output logic [3:0]  o_m_be,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_rd_data,
  input  logic        i_m_err
);

  localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

  arb_state_t state, next_state;
  arb_port_t  served;
  logic       txn_err;
  logic       data_req;
  logic       pick_d;
  logic       pick_i;
  logic       busy;
  logic       grant_cycle;
  logic       finish;
  logic       expire;
  logic       fetch_match;

  assign data_req = i_d_rd_en | i_d_wr_en;

`ifdef ZAP_ARB_FAIRNESS_EN
  localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);

  logic [BURST_W-1:0] burst_cnt;
  logic               force_fetch;

  assign force_fetch = i_i_rd_en && (burst_cnt == BURST_W'(MAX_DATA_BURST));
  assign pick_d      = data_req & ~force_fetch;

  // Counts back-to-back data grants only while a fetch is waiting
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_i) begin
        burst_cnt <= '0;
      end else if (pick_d) begin
        burst_cnt <= i_i_rd_en ? burst_cnt + 1'b1 : '0;
      end
    end
  end
`else
  logic unused_burst;
  assign unused_burst = (MAX_DATA_BURST > 0);
  assign pick_d       = data_req;
`endif

  assign pick_i = ~pick_d & i_i_rd_en;

  assign busy        = (state == GRANT_D) || (state == GRANT_I);
  // First cycle of a grant: o_m_req is still low, memory outputs get loaded
  assign grant_cycle = busy && !o_m_req;
  assign finish      = busy && o_m_req && (i_m_ack || i_m_err || expire);

  zap_arb_timeout #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .clear      (state == DONE),
    .load       (grant_cycle),
    .load_value (TO_LOAD),
    .en         (o_m_req),
    .expire     (expire)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          next_state = GRANT_D;
        end else if (pick_i) begin
          next_state = GRANT_I;
        end
      end
      GRANT_D, GRANT_I: begin
        if (finish) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      served      <= PORT_D;
      txn_err     <= 1'b0;
      o_m_req     <= 1'b0;
      o_m_we      <= 1'b0;
      o_m_address <= '0;
      o_m_wr_data <= '0;
      o_m_be      <= '0;
      o_d_rd_data <= '0;
      o_i_data    <= '0;
    end else begin
      if ((state == IDLE) && (pick_d || pick_i)) begin
        served <= pick_d ? PORT_D : PORT_I;
      end

      if (grant_cycle) begin
        o_m_req <= 1'b1;
        if (served == PORT_D) begin
          o_m_we      <= i_d_wr_en;
          o_m_address <= i_d_address;
          o_m_wr_data <= i_d_wr_data;
          o_m_be      <= i_d_wr_en ? i_d_be : 4'hF;
        end else begin
          o_m_we      <= 1'b0;
          o_m_address <= i_i_address;
          o_m_wr_data <= '0;
          o_m_be      <= 4'hF;
        end
      end

      if (finish) begin
        o_m_req <= 1'b0;
        // Anything other than a clean ack (error, or watchdog expiry) aborts
        txn_err <= i_m_err | ~i_m_ack;
        if (i_m_ack && !i_m_err && !o_m_we) begin
          if (served == PORT_D) begin
            o_d_rd_data <= i_m_rd_data;
          end else begin
            o_i_data <= i_m_rd_data;
          end
        end
      end
    end
  end

  // A fetch result is only delivered if the core still wants that PC;
  // otherwise it is dropped and the new PC is arbitrated from IDLE.
  assign fetch_match = i_i_rd_en && (o_m_address == i_i_address);

  assign o_d_stall = data_req & ~((state == DONE) && (served == PORT_D));
  assign o_d_abort = (state == DONE) && (served == PORT_D) && txn_err;
  assign o_i_valid = (state == DONE) && (served == PORT_I) && !txn_err && fetch_match;
  assign o_i_abort = (state == DONE) && (served == PORT_I) && txn_err && fetch_match;

endmodule
`default_nettype wire

// File: tb/tb_zap_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zap_mem_arbiter
//  Description : Self-checking bench for zap_mem_arbiter. Single transactions
//                come from a table of hand-computed records; arbitration,
//                redirect, late-ack, fairness and reset cases are scripted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_d_rd_en, i_d_wr_en;
  logic [31:0] i_d_address, i_d_wr_data;
  logic [3:0]  i_d_be;
  logic [31:0] o_d_rd_data;
  logic        o_d_stall, o_d_abort;
  logic        i_i_rd_en;
  logic [31:0] i_i_address;
  logic [31:0] o_i_data;
  logic        o_i_valid, o_i_abort;
  logic        o_m_req, o_m_we;
  logic [31:0] o_m_address, o_m_wr_data;
  logic [3:0]  o_m_be;
  logic        i_m_ack;
  logic [31:0] i_m_rd_data;
  logic        i_m_err;

  zap_mem_arbiter #(
    .TIMEOUT        (TIMEOUT),
    .MAX_DATA_BURST (4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_d_rd_en   (i_d_rd_en),
    .i_d_wr_en   (i_d_wr_en),
    .i_d_address (i_d_address),
    .i_d_wr_data (i_d_wr_data),
    .i_d_be      (i_d_be),
    .o_d_rd_data (o_d_rd_data),
    .o_d_stall   (o_d_stall),
    .o_d_abort   (o_d_abort),
    .i_i_rd_en   (i_i_rd_en),
    .i_i_address (i_i_address),
    .o_i_data    (o_i_data),
    .o_i_valid   (o_i_valid),
    .o_i_abort   (o_i_abort),
    .o_m_req     (o_m_req),
    .o_m_we      (o_m_we),
    .o_m_address (o_m_address),
    .o_m_wr_data (o_m_wr_data),
    .o_m_be      (o_m_be),
    .i_m_ack     (i_m_ack),
    .i_m_rd_data (i_m_rd_data),
    .i_m_err     (i_m_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Memory responder configuration
  int          req_cnt;
  int          mem_lat;
  bit          mem_err, mem_noack, mem_by_addr;
  logic [31:0] mem_rdata;

  // kind: 0 load, 1 store, 2 fetch; lat = req-high cycles before the response
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    bit          err;
    bit          noack;
    logic [31:0] rdata;
    int          exp_done;
    bit          exp_abort;
    logic [31:0] exp_data;
    bit          exp_we;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive the memory response for the current cycle
  task automatic cycle_begin();
    if (!o_m_req) req_cnt = 0;
    i_m_ack     = o_m_req && !mem_noack && (req_cnt == mem_lat);
    i_m_err     = o_m_req && mem_err && (req_cnt == mem_lat);
    i_m_rd_data = mem_by_addr ? (o_m_address ^ 32'h5A5A_0000) : mem_rdata;
    if (o_m_req) req_cnt++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          done_c;
    logic        abort_seen, valid_seen;
    bit          seen_req;
    logic        we_s;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wd_s;
    done_c = -1; seen_req = 0; abort_seen = 0; valid_seen = 0;
    we_s = 'x; be_s = 'x; addr_s = 'x; wd_s = 'x;
    mem_lat = v.lat; mem_err = v.err; mem_noack = v.noack;
    mem_by_addr = 0; mem_rdata = v.rdata;
    if (v.kind == 2) begin
      i_i_rd_en = 1; i_i_address = v.addr;
    end else begin
      i_d_rd_en = (v.kind == 0); i_d_wr_en = (v.kind == 1);
      i_d_address = v.addr; i_d_wr_data = v.wdata; i_d_be = v.be;
    end
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      cycle_begin();
      @(negedge i_clk);
      if (o_m_req && !seen_req) begin
        seen_req = 1; we_s = o_m_we; be_s = o_m_be; addr_s = o_m_address; wd_s = o_m_wr_data;
      end
      if ((v.kind == 2) ? (o_i_valid | o_i_abort) : !o_d_stall) begin
        done_c     = c;
        abort_seen = (v.kind == 2) ? o_i_abort : o_d_abort;
        valid_seen = o_i_valid;
      end
      @(posedge i_clk); #1;
    end
    i_d_rd_en = 0; i_d_wr_en = 0; i_i_rd_en = 0;
    check({tag, ".done_cycle"}, 32'(done_c), 32'(v.exp_done));
    check({tag, ".abort"}, {31'b0, abort_seen}, {31'b0, v.exp_abort});
    check({tag, ".m_we"}, {31'b0, we_s}, {31'b0, v.exp_we});
    check({tag, ".m_be"}, {28'b0, be_s}, {28'b0, v.exp_be});
    check({tag, ".m_addr"}, addr_s, v.addr);
    if (v.kind == 2) begin
      check({tag, ".i_valid"}, {31'b0, valid_seen}, {31'b0, !v.exp_abort});
      check({tag, ".i_data"}, o_i_data, v.exp_data);
    end else begin
      check({tag, ".d_rd_data"}, o_d_rd_data, v.exp_data);
    end
    if (v.kind == 1) check({tag, ".m_wr_data"}, wd_s, v.wdata);
    // Completion signals must be single-cycle pulses
    cycle_begin();
    @(negedge i_clk);
    check({tag, ".pulse_once"}, {29'b0, o_d_abort, o_i_valid, o_i_abort}, 32'h0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests, expected completion", tests);
    $fatal(1);
  end

  initial begin
    int          d_done, v_cnt, v_cyc, grants, d_grants, f_grants, f_at;
    logic [31:0] v_data, first_addr, last_addr;
    bit          prev_req, seen_req;

    //          kind addr          wdata         be     lat err noack rdata         done abort exp_data      we    be
    vecs[0] = '{0, 32'h0000_0100, 32'h0,        4'h0,  2, 0,  0,  32'hDEADBEEF,  5,  0,  32'hDEADBEEF, 1'b0, 4'hF};
    vecs[1] = '{1, 32'h0000_0200, 32'h12345678, 4'h3,  0, 0,  0,  32'hDEADBEEF,  3,  0,  32'hDEADBEEF, 1'b1, 4'h3};
    vecs[2] = '{0, 32'h0000_0104, 32'h0,        4'h0,  1, 0,  0,  32'hCAFEF00D,  4,  0,  32'hCAFEF00D, 1'b0, 4'hF};
    vecs[3] = '{0, 32'h0000_0108, 32'h0,        4'h0,  1, 1,  0,  32'h11111111,  4,  1,  32'hCAFEF00D, 1'b0, 4'hF};
    vecs[4] = '{1, 32'h0000_010C, 32'hA5A5A5A5, 4'hC,  3, 1,  1,  32'h22222222,  6,  1,  32'hCAFEF00D, 1'b1, 4'hC};
    vecs[5] = '{2, 32'h0000_0008, 32'h0,        4'h0,  1, 0,  0,  32'hE1A00000,  4,  0,  32'hE1A00000, 1'b0, 4'hF};
    vecs[6] = '{2, 32'h0000_000C, 32'h0,        4'h0,  0, 1,  0,  32'h33333333,  3,  1,  32'hE1A00000, 1'b0, 4'hF};
    vecs[7] = '{0, 32'h0000_0300, 32'h0,        4'h0,  0, 0,  1,  32'h44444444, 18,  1,  32'hCAFEF00D, 1'b0, 4'hF};

    i_reset_n = 0;
    i_d_rd_en = 0; i_d_wr_en = 0; i_d_address = 0; i_d_wr_data = 0; i_d_be = 0;
    i_i_rd_en = 0; i_i_address = 0;
    i_m_ack = 0; i_m_err = 0; i_m_rd_data = 0;
    req_cnt = 0; mem_lat = 0; mem_err = 0; mem_noack = 0; mem_by_addr = 0; mem_rdata = 0;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset.m_req_we", {30'b0, o_m_req, o_m_we}, 32'h0);
    check("reset.m_address", o_m_address, 32'h0);
    check("reset.m_wr_data", o_m_wr_data, 32'h0);
    check("reset.m_be", {28'b0, o_m_be}, 32'h0);
    check("reset.rd_data", o_d_rd_data, 32'h0);
    check("reset.i_data", o_i_data, 32'h0);
    check("reset.flags", {28'b0, o_d_stall, o_d_abort, o_i_valid, o_i_abort}, 32'h0);
    @(posedge i_clk); #1;
    i_reset_n = 1;
    @(posedge i_clk); #1;

    // Single transactions from the table
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // An acknowledge after the timeout abort must be ignored
    i_m_ack = 1; i_m_rd_data = 32'hBADBAD00; i_m_err = 0;
    @(negedge i_clk);
    check("late_ack.flags", {29'b0, o_m_req, o_d_abort, o_i_valid}, 32'h0);
    @(posedge i_clk); #1;
    i_m_ack = 0;
    @(negedge i_clk);
    check("late_ack.rd_data", o_d_rd_data, 32'hCAFEF00D);
    @(posedge i_clk); #1;

    // Simultaneous fetch and load: load first, then the fetch
    mem_by_addr = 1; mem_lat = 0; mem_err = 0; mem_noack = 0;
    i_d_rd_en = 1; i_d_address = 32'h40; i_i_rd_en = 1; i_i_address = 32'h0;
    d_done = -1; v_cnt = 0; v_cyc = -1; v_data = 'x; first_addr = 'x; seen_req = 0;
    for (int c = 0; c < 30; c++) begin
      cycle_begin();
      @(negedge i_clk);
      if (o_m_req && !seen_req) begin seen_req = 1; first_addr = o_m_address; end
      if (d_done < 0 && !o_d_stall) d_done = c;
      if (o_i_valid) begin v_cnt++; v_cyc = c; v_data = o_i_data; end
      @(posedge i_clk); #1;
      if (d_done >= 0) i_d_rd_en = 0;
      if (v_cnt > 0) i_i_rd_en = 0;
    end
    check("both.first_grant_addr", first_addr, 32'h40);
    check("both.data_done", 32'(d_done), 32'd3);
    check("both.rd_data", o_d_rd_data, 32'h5A5A0040);
    check("both.valid_count", 32'(v_cnt), 32'd1);
    check("both.valid_cycle", 32'(v_cyc), 32'd7);
    check("both.i_data", v_data, 32'h5A5A0000);

    // Branch redirect: PC 0x8 -> 0x20 while the fetch is outstanding
    mem_lat = 2;
    i_i_rd_en = 1; i_i_address = 32'h8;
    v_cnt = 0; v_cyc = -1; v_data = 'x; grants = 0; last_addr = 'x; prev_req = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) i_i_address = 32'h20;
      cycle_begin();
      @(negedge i_clk);
      if (o_m_req && !prev_req) begin grants++; last_addr = o_m_address; end
      prev_req = o_m_req;
      if (o_i_valid) begin v_cnt++; v_cyc = c; v_data = o_i_data; end
      @(posedge i_clk); #1;
      if (v_cnt > 0) i_i_rd_en = 0;
    end
    check("redirect.valid_count", 32'(v_cnt), 32'd1);
    check("redirect.valid_cycle", 32'(v_cyc), 32'd11);
    check("redirect.i_data", v_data, 32'h5A5A0020);
    check("redirect.grants", 32'(grants), 32'd2);
    check("redirect.last_addr", last_addr, 32'h20);

    // Continuous loads with a fetch pending
    mem_lat = 0;
    i_d_rd_en = 1; i_d_address = 32'h80; i_i_rd_en = 1; i_i_address = 32'h90;
    d_grants = 0; f_grants = 0; f_at = -1; v_cnt = 0; prev_req = 0;
    for (int c = 0; c < 60; c++) begin
      cycle_begin();
      @(negedge i_clk);
      if (o_m_req && !prev_req) begin
        if (o_m_address == 32'h80) begin
          if (f_grants == 0) d_grants++;
        end else if (o_m_address == 32'h90) begin
          if (f_grants == 0) f_at = d_grants;
          f_grants++;
        end
      end
      prev_req = o_m_req;
      if (o_i_valid) v_cnt++;
      @(posedge i_clk); #1;
      if (v_cnt > 0) i_i_rd_en = 0;
    end
    i_d_rd_en = 0; i_i_rd_en = 0;
    for (int c = 0; c < 6; c++) begin
      cycle_begin();
      @(posedge i_clk); #1;
    end
`ifdef ZAP_ARB_FAIRNESS_EN
    check("fair.data_grants_before_fetch", 32'(f_at), 32'd4);
    check("fair.fetch_grants", 32'(f_grants), 32'd1);
    check("fair.valid_count", 32'(v_cnt), 32'd1);
`else
    check("strict.fetch_grants", 32'(f_grants), 32'd0);
    check("strict.valid_count", 32'(v_cnt), 32'd0);
`endif

    // Reset asserted while a request is outstanding
    mem_by_addr = 0; mem_noack = 1; mem_err = 0; mem_lat = 0;
    i_d_rd_en = 1; i_d_address = 32'h400;
    seen_req = 0;
    for (int c = 0; c < 10 && !seen_req; c++) begin
      cycle_begin();
      @(negedge i_clk);
      if (o_m_req) seen_req = 1;
      else begin
        @(posedge i_clk); #1;
      end
    end
    check("rst_mid.req_seen", {31'b0, seen_req}, 32'd1);
    i_reset_n = 0;
    #1;
    check("rst_mid.m_req", {31'b0, o_m_req}, 32'd0);
    check("rst_mid.d_abort", {31'b0, o_d_abort}, 32'd0);
    @(posedge i_clk); #1;
    i_d_rd_en = 0; mem_noack = 0;
    @(posedge i_clk); #1;
    i_reset_n = 1;
    run_vec('{2, 32'h44, 32'h0, 4'h0, 0, 0, 0, 32'h600DF00D, 3, 0, 32'h600DF00D, 1'b0, 4'hF},
            "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zap_mem_arbiter.md
Name: zap_mem_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the ZAP core's instruction-fetch port and its data port.
- Presents the core-facing handshakes the core already expects: data stall, instruction valid, and abort on each port.
- Sits between zap_top and the memory model/cache, and replaces the dual-ported memory.
- Fixed priority: data over instruction. Each granted transaction is bounded by a timeout that raises an abort.

Parameters:
- TIMEOUT, 16: cycles o_m_req may stay high without i_m_ack before the transaction is aborted.
- MAX_DATA_BURST, 4: consecutive data grants allowed before a pending fetch is forced through. Used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_d_rd_en  in  1  data load request
- i_d_wr_en  in  1  data store request
- i_d_address  in  32  data address
- i_d_wr_data  in  32  store data
- i_d_be  in  4  byte enables
- o_d_rd_data  out  32  load data
- o_d_stall  out  1  data port stall
- o_d_abort  out  1  data abort, one-cycle pulse
- i_i_rd_en  in  1  fetch request
- i_i_address  in  32  fetch address (PC)
- o_i_data  out  32  fetched instruction
- o_i_valid  out  1  instruction valid, one-cycle pulse
- o_i_abort  out  1  instruction abort, one-cycle pulse
- o_m_req  out  1  memory request
- o_m_we  out  1  memory write
- o_m_address  out  32  memory address
- o_m_wr_data  out  32  memory write data
- o_m_be  out  4  memory byte enables
- i_m_ack  in  1  memory done
- i_m_rd_data  in  32  memory read data
- i_m_err  in  1  memory error

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Asynchronous assert, synchronous release.
- Reset mid-transaction drops o_m_req immediately. The memory side must tolerate the abandoned request.
- States:
  - IDLE: data request (rd or wr) pending -> GRANT_D. Else i_i_rd_en -> GRANT_I. Else stay.
  - GRANT_D / GRANT_I: grant cycle registers address, we, wr_data and be into the o_m_* outputs. o_m_req is high from the next cycle.
  - Exit from GRANT_D / GRANT_I: i_m_ack, i_m_err or timeout -> DONE.
  - DONE: one cycle, issues the completion, -> IDLE.
- Minimum latency, request to completion pulse: 4 cycles (IDLE, grant, ack, DONE).
- o_d_stall = (i_d_rd_en | i_d_wr_en) & ~(state==DONE & served data). It is combinational and deasserts exactly in the DONE cycle.
- Data request and all data inputs must be held stable while o_d_stall=1.
- Read data: o_d_rd_data / o_i_data are captured on i_m_ack and held until the next capture.
- Data completion:
  - Normal: o_d_abort=0 in the DONE cycle.
  - Error: i_m_err together with ack, or without ack, counts as error. Pulse o_d_abort in DONE; o_d_rd_data is unchanged.
- Timeout counter:
  - Counts cycles with o_m_req=1; cleared at grant.
  - Reaching TIMEOUT-1 without ack -> DONE with abort.
  - Any i_m_ack arriving after the abort is ignored.
- Fetch completion: o_i_valid=1 in DONE only if the captured address equals the current i_i_address and i_i_rd_en=1. Otherwise the fetch is silently dropped (branch redirect) and re-arbitrated.
- o_i_abort follows the same rule as o_i_valid, for error or timeout.
- Simultaneous data and fetch requests in IDLE: data wins.
- Requests arriving during a busy transaction wait; no preemption.
- Writes: o_m_we=1 and o_m_be=i_d_be. Reads drive o_m_be=4'hF.

Optional Feature:
- Macro: ZAP_ARB_FAIRNESS_EN.
- With the macro: a 3-bit counter (sized by clog2 of MAX_DATA_BURST+1) counts consecutive data grants while a fetch is pending.
  - At MAX_DATA_BURST the next IDLE decision grants the fetch.
  - The counter clears on any fetch grant.
- Without the macro: strict data priority, no counter logic.

Decomposition:
- Package zap_arb_pkg holds:
  - state encoding IDLE/GRANT_D/GRANT_I/DONE;
  - a served-port enum D/I;
  - the default TIMEOUT constant.
- One sub-module, zap_arb_timeout: a loadable down-counter with clear, enable and an expire output, reused per grant.

Test Plan:
- Single load, address 0x100, memory acks 2 cycles after req with 0xDEADBEEF -> o_d_stall low after 5 cycles, o_d_rd_data=0xDEADBEEF, o_m_we=0.
- Store of 0x12345678 with be=4'b0011 -> o_m_we=1, o_m_be=4'b0011, o_m_wr_data=0x12345678, no abort.
- Fetch at 0x0 and load at 0x40 asserted in the same cycle -> load served first, then fetch; o_i_valid pulses once with the fetch data.
- Fetch issued, PC changed from 0x8 to 0x20 before ack -> no o_i_valid for 0x8; the next grant uses 0x20.
- Memory never acks, TIMEOUT=16 -> o_d_abort pulses once about 18 cycles after the request; a late ack is ignored.
- ZAP_ARB_FAIRNESS_EN with continuous loads and a pending fetch -> fetch granted after exactly 4 data grants.
- Reset asserted mid-grant -> o_m_req drops immediately and state returns to IDLE.
